// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared constants, divider state type and duty clamp helper
package pwm_capture_pkg;

    localparam int CNT_W_DEFAULT = 10;
    localparam int DIV_W_DEFAULT = CNT_W_DEFAULT + 7;
    localparam logic [6:0] DUTY_MAX = 7'd100;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    function automatic logic [6:0] clamp_duty(input logic [31:0] q);
        return (q > 32'(DUTY_MAX)) ? DUTY_MAX : q[6:0];
    endfunction

endpackage

// File: rtl/pwm_div.sv
// rtl/pwm_div.sv - unsigned restoring divider, one quotient bit per clock
module pwm_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CW = $clog2(DIV_W + 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [CNT_W:0]   trial;
    logic             qbit;

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        trial = {rem_q, quo_q[DIV_W-1]};
        qbit  = (trial >= {1'b0, dsr_q});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !abort) begin
                    state_d = DIV_RUN;
                    cnt_d   = CW'(DIV_W);
                    quo_d   = dividend;
                    rem_d   = '0;
                    dsr_d   = divisor;
                end
            end
            DIV_RUN: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else if (cnt_q != '0) begin
                    quo_d = {quo_q[DIV_W-2:0], qbit};
                    rem_d = qbit ? CNT_W'(trial - {1'b0, dsr_q}) : trial[CNT_W-1:0];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
        end
    end

    assign busy     = (state_q == DIV_RUN);
    assign done     = busy && (cnt_q == '0) && !abort;
    assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty-cycle decoder with stuck-line and overrun reporting
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int SYNC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [6:0] dc_out,
    output logic       dc_valid,
    output logic       stuck,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

    logic [SYNC-1:0]  sync_q;
    logic             prev_q;
    logic             synced;
    logic             rise;
    logic             armed_q;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             stuck_hit;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] div_quo;

    // Synchronizer idles high so a line already high at reset release is not taken as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], pwm_in};
            prev_q <= synced;
        end
    end

    assign synced = sync_q[SYNC-1];
    assign rise   = synced && !prev_q;

    // Not stuck and not armed can only mean no edge has been seen since reset
    assign stuck_hit = !rise && !stuck && (period_cnt == CNT_NEAR);
    assign div_start = rise && armed_q && !busy;
    assign dividend  = DIV_W'(high_cnt) * DIV_W'(DUTY_MAX) + DIV_W'(period_cnt >> 1);

    pwm_div #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (stuck_hit),
        .dividend (dividend),
        .divisor  (period_cnt),
        .busy     (busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else begin
            if (period_cnt != CNT_MAX) period_cnt <= period_cnt + 1'b1;
            if (synced && high_cnt != CNT_MAX) high_cnt <= high_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q  <= 1'b0;
            stuck    <= 1'b0;
            dc_out   <= '0;
            dc_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dc_valid <= 1'b0;
            overrun  <= rise && armed_q && busy;
            if (stuck_hit) begin
                dc_out   <= synced ? DUTY_MAX : 7'd0;
                dc_valid <= 1'b1;
            end else if (div_done) begin
                dc_out   <= clamp_duty(32'(div_quo));
                dc_valid <= 1'b1;
            end
            if (rise) begin
                armed_q <= 1'b1;
                stuck   <= 1'b0;
            end else if (stuck_hit) begin
                armed_q <= 1'b0;
                stuck   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_in;
    logic [6:0] dc_out;
    logic       dc_valid;
    logic       stuck;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    bit x_seen = 1'b0;
    int v_cyc[$];
    int v_dc[$];
    int rise_q[$];

    // a report lands 21 tb cycles after pwm_in is driven high: 2 sync flops + 19
    localparam int LAT = 21;

    pwm_capture dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .dc_out   (dc_out),
        .dc_valid (dc_valid),
        .stuck    (stuck),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dc_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dc.push_back(int'(dc_out));
        end
        if (overrun === 1'b1) ovr_cnt++;
        if (rst_n === 1'b1 && $isunknown({dc_out, dc_valid, stuck, overrun, busy})) x_seen = 1'b1;
    end

    task automatic drive_cycles(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (level && pwm_in === 1'b0) rise_q.push_back(cyc);
            pwm_in = level;
        end
    endtask

    task automatic pwm_periods(input int high, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycles(1'b1, high);
            drive_cycles(1'b0, period - high);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v_cyc.delete();
        v_dc.delete();
        rise_q.delete();
        ovr_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dc_out, dc_valid, stuck, overrun, busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b want 0", {dc_out, dc_valid, stuck, overrun, busy});
        end
        apply_reset();
        drive_cycles(1'b0, 5);
        #1;
        n_cmp++;
        if ({dc_out, dc_valid, stuck, overrun, busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL post_reset_outputs got %b want 0", {dc_out, dc_valid, stuck, overrun, busy});
        end
    endtask

    task automatic test_half_duty();
        apply_reset();
        drive_cycles(1'b0, 5);
        pwm_periods(128, 256, 3);
        drive_cycles(1'b0, 5);
        #1;
        n_cmp++;
        if (v_cyc.size() != 2) begin
            n_bad++;
            $display("FAIL half_count got %0d want 2", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 2; i++) begin
            n_cmp++;
            if (v_dc[i] != 50 || v_cyc[i] != rise_q[i+1] + LAT) begin
                n_bad++;
                $display("FAIL half_report%0d got dc=%0d at %0d want dc=50 at %0d", i, v_dc[i], v_cyc[i], rise_q[i+1] + LAT);
            end
        end
    endtask

    task automatic test_duty_table();
        int hi_tab[4];
        int exp_tab[4];
        hi_tab  = '{64, 3, 253, 5};
        exp_tab = '{25, 1, 99, 2};
        for (int t = 0; t < 4; t++) begin
            apply_reset();
            drive_cycles(1'b0, 5);
            pwm_periods(hi_tab[t], 256, 2);
            drive_cycles(1'b0, 5);
            #1;
            n_cmp++;
            if (v_cyc.size() != 1 || v_dc[0] != exp_tab[t] || v_cyc[0] != rise_q[1] + LAT) begin
                n_bad++;
                $display("FAIL duty_h%0d got n=%0d dc=%0d at %0d want n=1 dc=%0d at %0d", hi_tab[t], v_cyc.size(), v_dc[0], v_cyc[0], exp_tab[t], rise_q[1] + LAT);
            end
        end
    endtask

    task automatic test_stuck();
        apply_reset();
        drive_cycles(1'b0, 1000);
        #1;
        n_cmp++;
        if (stuck !== 1'b0 || v_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL stuck_early got stuck=%b n=%0d want 0 0", stuck, v_cyc.size());
        end
        drive_cycles(1'b0, 30);
        #1;
        n_cmp++;
        if (stuck !== 1'b1 || v_cyc.size() != 1 || v_dc[0] != 0) begin
            n_bad++;
            $display("FAIL stuck_low got stuck=%b n=%0d dc=%0d want 1 1 0", stuck, v_cyc.size(), v_dc[0]);
        end
        drive_cycles(1'b1, 5);
        #1;
        n_cmp++;
        if (stuck !== 1'b0 || v_cyc.size() != 1) begin
            n_bad++;
            $display("FAIL stuck_clear got stuck=%b n=%0d want 0 1", stuck, v_cyc.size());
        end
        drive_cycles(1'b1, 1030);
        #1;
        n_cmp++;
        if (stuck !== 1'b1 || v_cyc.size() != 2 || v_dc[1] != 100 || dc_out !== 7'd100) begin
            n_bad++;
            $display("FAIL stuck_high got stuck=%b n=%0d dc=%0d want 1 2 100", stuck, v_cyc.size(), dc_out);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive_cycles(1'b0, 5);
        pwm_periods(5, 10, 8);
        drive_cycles(1'b0, 30);
        #1;
        n_cmp++;
        if (ovr_cnt != 3) begin
            n_bad++;
            $display("FAIL b2b_overruns got %0d want 3", ovr_cnt);
        end
        n_cmp++;
        if (v_cyc.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want 4", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            n_cmp++;
            if (v_dc[i] != 50 || v_cyc[i] != rise_q[2*i+1] + LAT) begin
                n_bad++;
                $display("FAIL b2b_report%0d got dc=%0d at %0d want dc=50 at %0d", i, v_dc[i], v_cyc[i], rise_q[2*i+1] + LAT);
            end
        end
        n_cmp++;
        if (x_seen) begin
            n_bad++;
            $display("FAIL b2b_no_x got x_seen=1 want 0");
        end
    endtask

    task automatic test_reset_mid_divide();
        apply_reset();
        drive_cycles(1'b0, 5);
        pwm_periods(128, 256, 1);
        drive_cycles(1'b1, 5);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rst_n = 1'b0;
        v_cyc.delete();
        v_dc.delete();
        rise_q.delete();
        #1;
        n_cmp++;
        if (dc_out !== 7'd0 || busy !== 1'b0 || dc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got dc=%0d busy=%b valid=%b want 0 0 0", dc_out, busy, dc_valid);
        end
        drive_cycles(1'b1, 3);
        rst_n = 1'b1;
        drive_cycles(1'b1, 120);
        drive_cycles(1'b0, 128);
        pwm_periods(128, 256, 2);
        drive_cycles(1'b0, 5);
        #1;
        n_cmp++;
        if (v_cyc.size() != 1 || v_dc[0] != 50 || v_cyc[0] != rise_q[1] + LAT) begin
            n_bad++;
            $display("FAIL mid_next got n=%0d dc=%0d at %0d want n=1 dc=50 at %0d", v_cyc.size(), v_dc[0], v_cyc[0], rise_q[1] + LAT);
        end
    endtask

    task automatic test_stuck_resume();
        apply_reset();
        drive_cycles(1'b0, 1030);
        #1;
        n_cmp++;
        if (stuck !== 1'b1 || v_cyc.size() != 1) begin
            n_bad++;
            $display("FAIL resume_stuck got stuck=%b n=%0d want 1 1", stuck, v_cyc.size());
        end
        drive_cycles(1'b1, 5);
        #1;
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_clear got %b want 0", stuck);
        end
        drive_cycles(1'b1, 187);
        drive_cycles(1'b0, 64);
        pwm_periods(192, 256, 1);
        #1;
        n_cmp++;
        if (v_cyc.size() != 2 || v_dc[1] != 75 || v_cyc[1] != rise_q[1] + LAT) begin
            n_bad++;
            $display("FAIL resume_report got n=%0d dc=%0d at %0d want n=2 dc=75 at %0d", v_cyc.size(), v_dc[1], v_cyc[1], rise_q[1] + LAT);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        test_reset();
        test_half_duty();
        test_duty_table();
        test_stuck();
        test_back_to_back();
        test_reset_mid_divide();
        test_stuck_resume();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
